adc_in: RTL

- Receive-side counterpart of the DAC output formatter.
- Registers the 14-bit offset-binary ADC bus and converts it to two's complement.
- Places the sample in a 27-bit signed word at a run-time bit position, and gates output with rx plus a post-enable settling blank.
- Tracks ADC overrange with a retriggerable hold flag and a saturating event counter for the control processor.

---
 rtl/adc_in_pkg.sv | 20 ++
 rtl/adc_ovr_monitor.sv | 55 +++++
 rtl/adc_in.sv | 109 ++++++++++
 3 files changed

// File: rtl/adc_in_pkg.sv
// rtl/adc_in_pkg.sv - shared types, constants and shift clamp for the ADC receive path
package adc_in_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int PIPE_LAT  = 3;
    localparam int OVR_CNT_W = 16;

    // Returns the effective MSB position + 1, limited to [lo, hi].
    function automatic logic [7:0] clamp_shift(input logic [7:0] sh, input int lo, input int hi);
        if (int'(sh) < lo) return 8'(lo);
        if (int'(sh) > hi) return 8'(hi);
        return sh;
    endfunction

endpackage

// File: rtl/adc_ovr_monitor.sv
// rtl/adc_ovr_monitor.sv - retriggerable overrange hold flag and saturating event counter
module adc_ovr_monitor
    import adc_in_pkg::*;
#(
    parameter int HOLD_CYCLES = 1024
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 ovr_evt,
    input  logic                 OVR_CLR,
    output logic                 OVR_FLAG,
    output logic [OVR_CNT_W-1:0] OVR_COUNT
);

    localparam int HW = (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);
    localparam logic [HW-1:0]        HOLD_LD = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0]        HOLD_ONE = HW'(1);
    localparam logic [OVR_CNT_W-1:0] CNT_ONE = {{(OVR_CNT_W-1){1'b0}}, 1'b1};

    logic [HW-1:0]        r_hold;
    logic                 r_flag;
    logic [OVR_CNT_W-1:0] r_count;

    // The flag is registered alongside the counter so it tracks (r_hold != 0) without a comb output.
    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_hold  <= '0;
            r_flag  <= 1'b0;
            r_count <= '0;
        end else begin
            if (ovr_evt) begin
                r_hold <= HOLD_LD;
                r_flag <= (HOLD_CYCLES != 0);
            end else if (r_hold != '0) begin
                r_hold <= r_hold - HOLD_ONE;
                r_flag <= (r_hold > HOLD_ONE);
            end else begin
                r_flag <= 1'b0;
            end

            if (ovr_evt) begin
                if (OVR_CLR)
                    r_count <= CNT_ONE;
                else if (r_count != '1)
                    r_count <= r_count + CNT_ONE;
            end else if (OVR_CLR) begin
                r_count <= '0;
            end
        end
    end

    assign OVR_FLAG  = r_flag;
    assign OVR_COUNT = r_count;

endmodule

// File: rtl/adc_in.sv
// rtl/adc_in.sv - offset-binary ADC capture, two's complement placement, rx gating and overrange tracking
module adc_in
    import adc_in_pkg::*;
#(
    parameter int in_width     = 14,
    parameter int out_width    = 27,
    parameter int BLANK_CYCLES = 16,
    parameter int HOLD_CYCLES  = 1024
) (
    input  logic                 clk_in,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic [in_width-1:0]  ADC_DATA,
    input  logic                 ADC_OVR,
    input  logic [7:0]           shift,
    input  logic                 OVR_CLR,
    output logic [out_width-1:0] DATA_OUT,
    output logic                 DATA_VALID,
    output logic                 OVR_FLAG,
    output logic [OVR_CNT_W-1:0] OVR_COUNT
);

    localparam int BW = (BLANK_CYCLES < 2) ? 1 : $clog2(BLANK_CYCLES);
    localparam int BLANK_LAST = (BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0;
    localparam logic [BW-1:0] BLANK_TC  = BW'(BLANK_LAST);
    localparam logic [BW-1:0] BLANK_ONE = BW'(1);

    logic [in_width-1:0]  r_d;
    logic                 r_ovr1;
    logic [in_width-1:0]  r_s;
    logic                 r_evt;
    state_t               r_state;
    logic [BW-1:0]        r_cnt;
    logic [out_width-1:0] r_data_out;
    logic                 r_valid;

    logic                 w_ovr;
    logic [7:0]           w_eff;
    logic [7:0]           w_amt;
    logic [out_width-1:0] w_sext;
    logic [out_width-1:0] w_placed;
    logic                 w_run;

    assign w_ovr    = r_ovr1 | (r_d == '0) | (r_d == '1);
    assign w_eff    = clamp_shift(shift, in_width, out_width);
    assign w_amt    = w_eff - 8'(in_width);
    assign w_sext   = {{(out_width-in_width){r_s[in_width-1]}}, r_s};
    assign w_placed = w_sext << w_amt;
    // rx is folded in so a drop mutes the very next output, not one state update later.
    assign w_run    = (r_state == RUN) & rx;

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_d        <= '0;
            r_ovr1     <= 1'b0;
            r_s        <= '0;
            r_evt      <= 1'b0;
            r_data_out <= '0;
            r_valid    <= 1'b0;
        end else begin
            r_d        <= ADC_DATA;
            r_ovr1     <= ADC_OVR;
            r_s        <= {~r_d[in_width-1], r_d[in_width-2:0]};
            r_evt      <= w_ovr & (r_state == RUN);
            r_data_out <= w_run ? w_placed : '0;
            r_valid    <= w_run;
        end
    end

    always_ff @(posedge clk_in or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else if (!rx) begin
            r_state <= IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_cnt   <= '0;
                    r_state <= (BLANK_CYCLES == 0) ? RUN : BLANK;
                end
                BLANK: begin
                    if (r_cnt == BLANK_TC)
                        r_state <= RUN;
                    else
                        r_cnt <= r_cnt + BLANK_ONE;
                end
                RUN:     r_state <= RUN;
                default: r_state <= IDLE;
            endcase
        end
    end

    adc_ovr_monitor #(
        .HOLD_CYCLES(HOLD_CYCLES)
    ) u_ovr_mon (
        .clk_in    (clk_in),
        .reset_n   (reset_n),
        .ovr_evt   (r_evt),
        .OVR_CLR   (OVR_CLR),
        .OVR_FLAG  (OVR_FLAG),
        .OVR_COUNT (OVR_COUNT)
    );

    assign DATA_OUT   = r_data_out;
    assign DATA_VALID = r_valid;

endmodule
